// File: rtl/rot_cmd_parser_if.sv
// Byte-stream input and decoded-command output handshakes of the rotation command parser.
`ifndef DATA_WIDTH
`define DATA_WIDTH 24
`endif

interface rot_cmd_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_dir;
    logic [DATA_WIDTH-1:0] out_rot;
    logic                  out_ready;

    // master: byte source / command sink; slave: the parser itself
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_dir, out_rot
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_dir, out_rot
    );
endinterface

// File: rtl/rot_cmd_parser.sv
// Decodes an ASCII "L68\nR1000\n" style byte stream into (dir, rot) commands,
// with command/error counting, sticky overflow and end-of-stream detection.
`ifndef DATA_WIDTH
`define DATA_WIDTH 24
`endif

module rot_cmd_parser #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    rot_cmd_if.slave              bus,
    output logic [DATA_WIDTH-1:0] cmd_count,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  overflow,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DIGITS = 3'd1,
        S_EMIT   = 3'd2,
        S_SKIP   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    // acc*10 + d, clamped to all-ones; MSB of the result flags the clamp
    function automatic logic [DATA_WIDTH:0] mac10_sat(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [3:0]            d
    );
        logic [DATA_WIDTH+3:0] wide;
        wide = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{DATA_WIDTH{1'b0}}, d};
        if (wide > {4'b0, {DATA_WIDTH{1'b1}}})
            return {1'b1, {DATA_WIDTH{1'b1}}};
        return {1'b0, wide[DATA_WIDTH-1:0]};
    endfunction

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    dir_t                  dir_q, dir_d;
    dir_t                  out_dir_q, out_dir_d;
    logic [DATA_WIDTH-1:0] out_rot_q, out_rot_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic                  ovf_q, ovf_d;

    logic                  accept;
    logic                  is_l, is_r, is_term, is_digit;
    logic [DATA_WIDTH:0]   mac_res;

    assign accept   = bus.in_valid && bus.in_ready;
    assign is_l     = (bus.in_data == 8'h4C);
    assign is_r     = (bus.in_data == 8'h52);
    assign is_term  = (bus.in_data == 8'h0A) || (bus.in_data == 8'h0D);
    assign is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
    assign mac_res  = mac10_sat(acc_q, bus.in_data[3:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            dir_q     <= DIR_RIGHT;
            out_dir_q <= DIR_RIGHT;
            out_rot_q <= '0;
            last_q    <= 1'b0;
            cmd_q     <= '0;
            err_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            dir_q     <= dir_d;
            out_dir_q <= out_dir_d;
            out_rot_q <= out_rot_d;
            last_q    <= last_d;
            cmd_q     <= cmd_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    // A byte carrying in_last never leaves the FSM waiting for more input.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) begin
                if (bus.in_last)        state_d = S_DONE;
                else if (is_l || is_r)  state_d = S_DIGITS;
                else if (!is_term)      state_d = S_SKIP;
            end
            S_DIGITS: if (accept) begin
                if (is_digit)           state_d = bus.in_last ? S_EMIT : S_DIGITS;
                else if (is_term)       state_d = S_EMIT;
                else                    state_d = bus.in_last ? S_DONE : S_SKIP;
            end
            S_SKIP: if (accept) begin
                if (bus.in_last)        state_d = S_DONE;
                else if (is_term)       state_d = S_IDLE;
            end
            S_EMIT: if (bus.out_ready) begin
                state_d = last_q ? S_DONE : S_IDLE;
            end
            S_DONE:                     state_d = S_DONE;
            default:                    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        done          = 1'b0;
        case (state_q)
            S_IDLE, S_DIGITS, S_SKIP: bus.in_ready  = 1'b1;
            S_EMIT:                   bus.out_valid = 1'b1;
            S_DONE:                   done          = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        dir_d     = dir_q;
        out_dir_d = out_dir_q;
        out_rot_d = out_rot_q;
        last_d    = last_q;
        cmd_d     = cmd_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: if (accept) begin
                if (is_l || is_r) begin
                    acc_d = '0;
                    dir_d = is_l ? DIR_LEFT : DIR_RIGHT;
                end else if (!is_term) begin
                    err_d = sat_inc(err_q);
                end
            end
            S_DIGITS: if (accept) begin
                if (is_digit) begin
                    acc_d = mac_res[DATA_WIDTH-1:0];
                    if (mac_res[DATA_WIDTH]) ovf_d = 1'b1;
                    // Last byte is a digit: emit the freshly accumulated value directly
                    if (bus.in_last) begin
                        out_rot_d = mac_res[DATA_WIDTH-1:0];
                        out_dir_d = dir_q;
                        last_d    = 1'b1;
                    end
                end else if (is_term) begin
                    out_rot_d = acc_q;
                    out_dir_d = dir_q;
                    last_d    = bus.in_last;
                end else begin
                    err_d = sat_inc(err_q);
                end
            end
            S_EMIT: if (bus.out_ready) begin
                cmd_d = cmd_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.out_dir = out_dir_q;
    assign bus.out_rot = out_rot_q;
    assign cmd_count   = cmd_q;
    assign err_count   = err_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_rot_cmd_parser.sv
// Directed bench for rot_cmd_parser: ASCII streams in, decoded commands and status checked.
module tb_rot_cmd_parser;
    localparam int DW = 24;
    localparam int EW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] cmd_count;
    logic [EW-1:0] err_count;
    logic          overflow;
    logic          done;

    logic          ord_level  = 1'b1;
    logic          ord_toggle = 1'b0;
    int unsigned   cyc = 0;

    int            checks   = 0;
    int            failures = 0;

    logic [DW:0]   outq[$];
    int            qbase = 0;
    int            stall_err = 0;
    int            ready_in_emit = 0;
    int            post_done_acc = 0;
    logic          prev_v = 1'b0;
    logic          prev_hs = 1'b0;
    logic [DW:0]   prev_dat = '0;

    rot_cmd_if #(.DATA_WIDTH(DW)) bus ();

    assign bus.out_ready = ord_toggle ? (cyc % 3 == 0) : ord_level;

    rot_cmd_parser #(.DATA_WIDTH(DW), .ERR_WIDTH(EW)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .cmd_count (cmd_count),
        .err_count (err_count),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Records handshakes and watches protocol properties across the whole run
    always @(posedge clock) begin
        if (reset) begin
            prev_v  <= 1'b0;
            prev_hs <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready)
                outq.push_back({bus.out_dir, bus.out_rot});
            if (bus.in_valid && bus.in_ready && done)
                post_done_acc <= post_done_acc + 1;
            if (bus.out_valid && bus.in_ready)
                ready_in_emit <= ready_in_emit + 1;
            if (prev_v && !prev_hs &&
                (!bus.out_valid || ({bus.out_dir, bus.out_rot} !== prev_dat)))
                stall_err <= stall_err + 1;
            prev_v   <= bus.out_valid;
            prev_hs  <= bus.out_valid && bus.out_ready;
            prev_dat <= {bus.out_dir, bus.out_rot};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW:0] get(input int i);
        if (qbase + i < outq.size()) return outq[qbase + i];
        return 'x;
    endfunction

    task automatic send_byte(input byte b, input bit last);
        logic r;
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            r = bus.in_ready;
            @(posedge clock);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("byte_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_str(input string s, input bit last_end);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_end && (i == s.len() - 1));
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int t = 0; t < budget; t++) begin
            if (done === 1'b1) break;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_outs(input int n, input int budget);
        for (int t = 0; t < budget; t++) begin
            if (outq.size() - qbase >= n) break;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        qbase = outq.size();
    endtask

    initial begin
        int s0, e0, p0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_dir",   {31'd0, bus.out_dir},   32'd0);
        chk("rst_out_rot",   {8'd0, bus.out_rot},    32'd0);
        chk("rst_cmd_count", {8'd0, cmd_count},      32'd0);
        chk("rst_err_count", {24'd0, err_count},     32'd0);
        chk("rst_overflow",  {31'd0, overflow},      32'd0);
        chk("rst_done",      {31'd0, done},          32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);

        // Five commands, sink always ready
        qbase = outq.size();
        send_str("L68\nL30\nR48\nL5\nR60\n", 1'b1);
        wait_done(50);
        chk("t1_done",  {31'd0, done}, 32'd1);
        chk("t1_nout",  outq.size() - qbase, 32'd5);
        chk("t1_o0",    get(0), {7'd0, 1'b1, 24'd68});
        chk("t1_o1",    get(1), {7'd0, 1'b1, 24'd30});
        chk("t1_o2",    get(2), {7'd0, 1'b0, 24'd48});
        chk("t1_o3",    get(3), {7'd0, 1'b1, 24'd5});
        chk("t1_o4",    get(4), {7'd0, 1'b0, 24'd60});
        chk("t1_cmd",   {8'd0, cmd_count},  32'd5);
        chk("t1_err",   {24'd0, err_count}, 32'd0);
        p0 = post_done_acc;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h4C;
        repeat (5) @(posedge clock);
        #1;
        chk("t1_rdy_after_done", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        chk("t1_acc_after_done", post_done_acc - p0, 32'd0);
        chk("t1_cmd_hold", {8'd0, cmd_count}, 32'd5);

        // Same stream, sink ready one cycle in three
        do_reset();
        ord_toggle = 1'b1;
        s0 = stall_err;
        e0 = ready_in_emit;
        send_str("L68\nL30\nR48\nL5\nR60\n", 1'b1);
        wait_done(300);
        ord_toggle = 1'b0;
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_nout", outq.size() - qbase, 32'd5);
        chk("t2_o0",   get(0), {7'd0, 1'b1, 24'd68});
        chk("t2_o1",   get(1), {7'd0, 1'b1, 24'd30});
        chk("t2_o2",   get(2), {7'd0, 1'b0, 24'd48});
        chk("t2_o3",   get(3), {7'd0, 1'b1, 24'd5});
        chk("t2_o4",   get(4), {7'd0, 1'b0, 24'd60});
        chk("t2_stall_stable", stall_err - s0, 32'd0);
        chk("t2_ready_in_emit", ready_in_emit - e0, 32'd0);
        chk("t2_cmd",  {8'd0, cmd_count}, 32'd5);

        // Malformed lines and a bare letter
        do_reset();
        send_str("X12\nR7\nL3a\nR\n", 1'b1);
        wait_done(100);
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_nout", outq.size() - qbase, 32'd2);
        chk("t3_o0",   get(0), {7'd0, 1'b0, 24'd7});
        chk("t3_o1",   get(1), {7'd0, 1'b0, 24'd0});
        chk("t3_err",  {24'd0, err_count}, 32'd2);
        chk("t3_cmd",  {8'd0, cmd_count},  32'd2);

        // Saturating rotation; overflow sticks through a later good line
        do_reset();
        send_str("R99999999\n", 1'b0);
        wait_outs(1, 50);
        chk("t4_ovf_first", {31'd0, overflow}, 32'd1);
        send_str("L5\n", 1'b1);
        wait_done(50);
        chk("t4_o0",  get(0), {7'd0, 1'b0, 24'd16777215});
        chk("t4_o1",  get(1), {7'd0, 1'b1, 24'd5});
        chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("t4_done", {31'd0, done}, 32'd1);

        // in_last on a digit, no newline
        do_reset();
        send_str("R1000", 1'b1);
        wait_done(50);
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_nout", outq.size() - qbase, 32'd1);
        chk("t5_o0",   get(0), {7'd0, 1'b0, 24'd1000});
        chk("t5_cmd",  {8'd0, cmd_count}, 32'd1);

        // Reset while a command is held in EMIT
        do_reset();
        ord_level = 1'b0;
        send_str("X\nL1\n", 1'b0);
        for (int t = 0; t < 20; t++) begin
            if (bus.out_valid === 1'b1) break;
            @(posedge clock);
            #1;
        end
        chk("t6_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t6_pre_err",   {24'd0, err_count},     32'd1);
        do_reset();
        chk("t6_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_err",   {24'd0, err_count},     32'd0);
        chk("t6_cmd",   {8'd0, cmd_count},      32'd0);
        ord_level = 1'b1;
        send_str("L1\n", 1'b1);
        wait_done(50);
        chk("t6_nout", outq.size() - qbase, 32'd1);
        chk("t6_o0",   get(0), {7'd0, 1'b1, 24'd1});

        // Reset in the middle of a number
        do_reset();
        send_str("Q\nR12", 1'b0);
        chk("t7_pre_err", {24'd0, err_count}, 32'd1);
        do_reset();
        chk("t7_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t7_err",   {24'd0, err_count},     32'd0);
        chk("t7_cmd",   {8'd0, cmd_count},      32'd0);
        send_str("L1\n", 1'b1);
        wait_done(50);
        chk("t7_nout", outq.size() - qbase, 32'd1);
        chk("t7_o0",   get(0), {7'd0, 1'b1, 24'd1});
        chk("t7_cmd_after", {8'd0, cmd_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rot_cmd_parser.md
# rot_cmd_parser

Byte-serial front end for the dial-lock datapath. It consumes an ASCII rotation-command stream such as `L68\nR1000\n` one byte per handshake and emits decoded `(dir, rot)` commands on a valid/ready interface. That output drives `lock_over_zero`'s `dir`/`rot`/`en` inputs, and it replaces behavioural file parsing with synthesizable hardware. It also reports command count, malformed-input and overflow status.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (24): width of decoded rotation and command count.
- `ERR_WIDTH`, default 8: width of the saturating error counter.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: byte available.
- `in_data` in 8: ASCII byte.
- `in_last` in 1: marks the final byte of the stream; qualified by `in_valid`.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `out_valid` out 1: decoded command available.
- `out_dir` out 1, `DIR_T`: LEFT=1, RIGHT=0.
- `out_rot` out `DATA_WIDTH`: decoded unsigned rotation.
- `out_ready` in 1: downstream accepts when `out_valid && out_ready`. Feed this to `lock_over_zero` `en` as `out_valid && out_ready`.
- `cmd_count` out `DATA_WIDTH`: commands emitted.
- `err_count` out `ERR_WIDTH`: malformed lines, saturating.
- `overflow` out 1: sticky; a rotation exceeded `DATA_WIDTH` bits.
- `done` out 1: sticky; the stream is fully processed.

## Operation
- States:
  - IDLE: expects a command letter.
  - DIGITS: accumulating the value.
  - EMIT: holding output.
  - SKIP: discarding the rest of a bad line.
  - DONE.
- Reset: state IDLE, accumulator 0, `out_valid`=0, `out_dir`=RIGHT, `out_rot`=0, `cmd_count`=0, `err_count`=0, `overflow`=0, `done`=0.
- `in_ready` = 1 in IDLE, DIGITS and SKIP; 0 in EMIT and DONE.
- IDLE, accepted byte:
  - `L` (0x4C) → dir=LEFT, acc=0, go to DIGITS.
  - `R` (0x52) → dir=RIGHT, acc=0, go to DIGITS.
  - LF (0x0A) or CR (0x0D) → ignored, stay in IDLE.
  - Any other byte → `err_count`++ and go to SKIP.
- DIGITS, accepted byte:
  - `0`-`9` → acc = acc*10 + digit. Compute as (acc<<3)+(acc<<1)+d in `DATA_WIDTH`+4 bits. If the result exceeds 2^`DATA_WIDTH`−1, acc saturates to all-ones and `overflow` is set.
  - LF or CR → latch `out_rot`=acc and `out_dir`, go to EMIT. A letter with no digits emits rot=0.
  - Any other byte → `err_count`++, go to SKIP; nothing is emitted for that line.
- SKIP: discard bytes until LF or CR, then return to IDLE.
- EMIT: `out_valid`=1; `out_dir`/`out_rot` are stable until the handshake. On `out_ready`:
  - `cmd_count`++.
  - Next state is DONE if the terminating byte was `in_last`, else IDLE.
  - `out_valid` drops the next cycle.
- `in_last` handling:
  - In DIGITS with a digit byte: the digit is accumulated, then the state goes to EMIT with a pending-done flag.
  - In IDLE or SKIP, or in DIGITS on a terminator byte: the state goes to DONE after that byte, or via EMIT if the byte terminated a valid command.
  - A bad byte carrying `in_last` counts as an error and goes to DONE.
- DONE: `done`=1 and `in_ready`=0 until reset.
- Counters: `err_count` saturates at all-ones. `cmd_count` wraps modulo 2^`DATA_WIDTH`.
- Reset asserted mid-line or in EMIT: all state clears on that edge. The pending command is dropped and `out_valid` is 0 the following cycle.

## Timing
- Every state transition is registered; one byte is accepted per cycle when ready.
- A terminator accepted at edge N gives `out_valid`=1 from edge N onward (visible in cycle N+1).
- Earliest handshake is cycle N+1, giving `in_ready`=1 again in cycle N+2.
- Minimum cost per command: (bytes in line) + 1 cycles.
- `out_valid` and data are held indefinitely while `out_ready`=0. `in_valid` and `in_data` are ignored while `in_ready`=0.
- `cmd_count`, `err_count` and `overflow` update on the edge of the triggering handshake or byte.
- `done` rises on the edge that completes the final byte or the final output handshake.

## Test plan
- Stream `L68\nL30\nR48\nL5\nR60\n` with `in_last` on the final LF and `out_ready`=1 → five outputs, in order (1,68), (1,30), (0,48), (1,5), (0,60); `cmd_count`=5; `err_count`=0; `done`=1; no bytes accepted afterward.
- Same stream with `out_ready` toggled 1-of-3 cycles → identical output sequence; `out_rot` stable while stalled; `in_ready`=0 throughout EMIT.
- `X12\nR7\nL3a\nR\n` → outputs (0,7), (0,0); `err_count`=2.
- `R99999999\n` with `DATA_WIDTH`=24 → `out_rot`=16777215 and `overflow`=1, which stays set after the next good line.
- `R1000` with `in_last` on `0` and no newline → a single output (0,1000), then `done`=1.
- Reset asserted while in EMIT, and separately mid-digit → `out_valid`=0 and all counters 0 the next cycle; `L1\n` then emits (1,1).
